cache_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single-port line cache between NUM_REQ hardware-worker requesters (tensor load/store units).
- Latches one requester's transaction, drives the cache port until cache done, then returns load data and a one-cycle done pulse to that requester.
- Includes a per-transaction timeout watchdog so a stalled memory cannot hang the workers.

---
 rtl/cache_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_cache_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_arbiter
// Purpose  : Round-robin arbiter and sequencer that shares a single-port line
//            cache between NUM_REQ requesters. It includes a per-transaction
//            timeout watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module cache_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_w_en,
    input  logic [NUM_REQ-1:0]    req_through,
    input  logic [NUM_REQ*24-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_data_store,
    output logic [NUM_REQ-1:0]    req_done,
    output logic                  req_err,
    output logic [31:0]           req_data_load,
    output logic                  cache_w_en,
    output logic                  cache_r_en,
    output logic                  cache_write_through,
    output logic                  cache_read_through,
    output logic [23:0]           cache_addr,
    output logic [31:0]           cache_data_store,
    input  logic [31:0]           cache_data_load,
    input  logic                  cache_done,
    output logic                  busy,
    output logic [ID_W-1:0]       owner
);

    localparam int               CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     owner_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                lat_w_q;
    logic [23:0]         lat_addr_q;
    logic [31:0]         lat_data_q;
    logic [NUM_REQ-1:0]  done_q;
    logic                err_q;
    logic [31:0]         load_q;
    logic                w_en_q;
    logic                r_en_q;
    logic                wt_q;
    logic                rt_q;
    logic                busy_q;

    logic [23:0]         addr_arr [NUM_REQ];
    logic [31:0]         data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*24 +: 24];
        assign data_arr[g] = req_data_store[g*32 +: 32];
    end

    // Rotate the request vector so bit 0 is the highest-priority requester.
    logic [2*NUM_REQ-1:0] dbl_d;
    logic [NUM_REQ-1:0]   rot_d;
    logic                 gnt_found_d;
    logic [ID_W-1:0]      gnt_off_d;
    logic [ID_W:0]        gnt_sum_d;
    logic [ID_W:0]        gnt_wrap_d;
    logic [ID_W-1:0]      gnt_idx_d;
    logic [ID_W:0]        own_inc_d;
    logic [ID_W-1:0]      rr_next_d;

    assign dbl_d = {req_valid, req_valid} >> rr_ptr_q;
    assign rot_d = dbl_d[NUM_REQ-1:0];

    always_comb begin
        gnt_found_d = 1'b0;
        gnt_off_d   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_d[k]) begin
                gnt_found_d = 1'b1;
                gnt_off_d   = ID_W'(k);
            end
        end
    end

    assign gnt_sum_d  = {1'b0, rr_ptr_q} + {1'b0, gnt_off_d};
    assign gnt_wrap_d = gnt_sum_d - NUM_REQ_W;
    assign gnt_idx_d  = (gnt_sum_d >= NUM_REQ_W) ? gnt_wrap_d[ID_W-1:0] : gnt_sum_d[ID_W-1:0];

    assign own_inc_d  = {1'b0, owner_q} + (ID_W + 1)'(1);
    assign rr_next_d  = (own_inc_d >= NUM_REQ_W) ? '0 : own_inc_d[ID_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            lat_w_q    <= 1'b0;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            load_q     <= '0;
            w_en_q     <= 1'b0;
            r_en_q     <= 1'b0;
            wt_q       <= 1'b0;
            rt_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_found_d) begin
                        owner_q    <= gnt_idx_d;
                        cnt_q      <= '0;
                        lat_w_q    <= req_w_en[gnt_idx_d];
                        lat_addr_q <= addr_arr[gnt_idx_d];
                        lat_data_q <= data_arr[gnt_idx_d];
                        w_en_q     <= req_w_en[gnt_idx_d];
                        r_en_q     <= !req_w_en[gnt_idx_d];
                        wt_q       <= req_w_en[gnt_idx_d] & req_through[gnt_idx_d];
                        rt_q       <= !req_w_en[gnt_idx_d] & req_through[gnt_idx_d];
                        busy_q     <= 1'b1;
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A completion in the watchdog's final cycle still wins.
                    if (cache_done || (cnt_q == CNT_LAST)) begin
                        w_en_q  <= 1'b0;
                        r_en_q  <= 1'b0;
                        wt_q    <= 1'b0;
                        rt_q    <= 1'b0;
                        done_q  <= ONE_HOT0 << owner_q;
                        err_q   <= !cache_done;
                        load_q  <= (cache_done && !lat_w_q) ? cache_data_load : '0;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    done_q   <= '0;
                    err_q    <= 1'b0;
                    load_q   <= '0;
                    rr_ptr_q <= rr_next_d;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_done            = done_q;
    assign req_err             = err_q;
    assign req_data_load       = load_q;
    assign cache_w_en          = w_en_q;
    assign cache_r_en          = r_en_q;
    assign cache_write_through = wt_q;
    assign cache_read_through  = rt_q;
    assign cache_addr          = lat_addr_q;
    assign cache_data_store    = lat_data_q;
    assign busy                = busy_q;
    assign owner               = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_arbiter
// Purpose  : Self-checking bench for cache_arbiter with a transaction-level
//            round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_w_en;
    logic [N-1:0]  req_through;
    logic [N*24-1:0] req_addr;
    logic [N*32-1:0] req_data_store;
    logic [N-1:0]  req_done;
    logic          req_err;
    logic [31:0]   req_data_load;
    logic          cache_w_en, cache_r_en, cache_write_through, cache_read_through;
    logic [23:0]   cache_addr;
    logic [31:0]   cache_data_store;
    logic [31:0]   cache_data_load;
    logic          cache_done;
    logic          busy;
    logic [1:0]    owner;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending requests and the round-robin pointer.
    bit          pend   [N];
    logic        w_m    [N];
    logic        th_m   [N];
    logic [23:0] addr_m [N];
    logic [31:0] data_m [N];
    int          rr_m;

    cache_arbiter #(.NUM_REQ(N), .ID_W(2), .TIMEOUT(TMO)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_w_en            (req_w_en),
        .req_through         (req_through),
        .req_addr            (req_addr),
        .req_data_store      (req_data_store),
        .req_done            (req_done),
        .req_err             (req_err),
        .req_data_load       (req_data_load),
        .cache_w_en          (cache_w_en),
        .cache_r_en          (cache_r_en),
        .cache_write_through (cache_write_through),
        .cache_read_through  (cache_read_through),
        .cache_addr          (cache_addr),
        .cache_data_store    (cache_data_store),
        .cache_data_load     (cache_data_load),
        .cache_done          (cache_done),
        .busy                (busy),
        .owner               (owner)
    );

    always #5 clk = ~clk;

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (pend[(rr_m + k) % N]) return (rr_m + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst            = 1'b1;
        req_valid      = '0;
        req_w_en       = '0;
        req_through    = '0;
        req_addr       = '0;
        req_data_store = '0;
        cache_done     = 1'b0;
        cache_data_load = '0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        rr_m = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_req(input int i, input logic w, input logic th,
                             input logic [23:0] a, input logic [31:0] d);
        pend[i]   = 1'b1;
        w_m[i]    = w;
        th_m[i]   = th;
        addr_m[i] = a;
        data_m[i] = d;
        req_valid[i]   = 1'b1;
        req_w_en[i]    = w;
        req_through[i] = th;
        req_addr[i*24 +: 24]       = a;
        req_data_store[i*32 +: 32] = d;
    endtask

    // Called at a negedge in IDLE with at least one pending request; returns
    // at the negedge of the IDLE cycle that follows the response.
    task automatic serve(input int lat, input logic [31:0] rdata, output int served);
        int          exp;
        int          n;
        logic        exp_err;
        logic [31:0] exp_load;
        logic [3:0]  exp_en;
        exp     = pick();
        served  = exp;
        exp_err = 1'b1;
        if (exp < 0) begin
            checks++; failures++;
            $display("FAIL serve_no_pending: got none required a pending request");
            return;
        end
        exp_en = {w_m[exp], !w_m[exp], w_m[exp] & th_m[exp], !w_m[exp] & th_m[exp]};
        @(negedge clk);
        n = 1;
        while (1) begin
            checks++;
            if (busy !== 1'b1 || owner !== 2'(exp)) begin
                failures++;
                $display("FAIL busy_owner: got busy=%b owner=%0d required busy=1 owner=%0d", busy, owner, exp);
            end
            checks++;
            if ({cache_w_en, cache_r_en, cache_write_through, cache_read_through} !== exp_en) begin
                failures++;
                $display("FAIL cache_enables: got %b required %b",
                         {cache_w_en, cache_r_en, cache_write_through, cache_read_through}, exp_en);
            end
            checks++;
            if (cache_addr !== addr_m[exp] || cache_data_store !== data_m[exp]) begin
                failures++;
                $display("FAIL cache_port: got addr=%h data=%h required addr=%h data=%h",
                         cache_addr, cache_data_store, addr_m[exp], data_m[exp]);
            end
            // Owner's inputs wander after the grant; the cache port must not follow.
            req_addr[exp*24 +: 24]       = 24'($urandom);
            req_data_store[exp*32 +: 32] = $urandom;
            req_through[exp]             = 1'($urandom);
            req_w_en[exp]                = 1'($urandom);
            if (n == lat) begin
                cache_done      = 1'b1;
                cache_data_load = rdata;
                exp_err         = 1'b0;
                break;
            end
            if (n == TMO) break;
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        exp_load = (exp_err || w_m[exp]) ? 32'h0 : rdata;
        checks++;
        if (req_done !== (4'b0001 << exp) || req_err !== exp_err || req_data_load !== exp_load) begin
            failures++;
            $display("FAIL resp: got done=%b err=%b load=%h required done=%b err=%b load=%h",
                     req_done, req_err, req_data_load, 4'b0001 << exp, exp_err, exp_load);
        end
        checks++;
        if (busy !== 1'b1 || cache_w_en !== 1'b0 || cache_r_en !== 1'b0) begin
            failures++;
            $display("FAIL resp_state: got busy=%b w=%b r=%b required 1 0 0", busy, cache_w_en, cache_r_en);
        end
        cache_done     = 1'b0;
        req_valid[exp] = 1'b0;
        pend[exp]      = 1'b0;
        rr_m           = (exp + 1) % N;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_done !== '0 || req_err !== 1'b0 || req_data_load !== '0 ||
            cache_w_en !== 1'b0 || cache_r_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_resp: got busy=%b done=%b err=%b load=%h w=%b r=%b required all 0",
                     busy, req_done, req_err, req_data_load, cache_w_en, cache_r_en);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, owner, req_done, req_err, req_data_load, cache_w_en, cache_r_en,
             cache_write_through, cache_read_through, cache_addr, cache_data_store} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b owner=%0d done=%b addr=%h required all 0",
                     busy, owner, req_done, cache_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int s;
        drive_req(2, 1'b0, 1'b0, 24'h000100, 32'h0BAD_F00D);
        serve(2, 32'hDEAD_BEEF, s);
        // Pointer now at 3: of requesters 2 and 3, 3 goes first.
        drive_req(2, 1'b0, 1'b1, 24'h000200, 32'h1);
        drive_req(3, 1'b1, 1'b0, 24'h000300, 32'h2);
        serve(1, 32'h1111_2222, s);
        checks++;
        if (s !== 3) begin failures++; $display("FAIL rr_after_read: got %0d required 3", s); end
        serve(2, 32'h3333_4444, s);
    endtask

    task automatic test_write_through();
        int s;
        drive_req(1, 1'b1, 1'b1, 24'hABCDEF, 32'h1234_5678);
        serve(3, 32'hFFFF_FFFF, s);
    endtask

    task automatic test_round_robin();
        int s;
        do_reset();
        for (int i = 0; i < N; i++) drive_req(i, 1'($urandom), 1'($urandom), 24'($urandom), $urandom);
        for (int k = 0; k < 5; k++) begin
            serve(1, $urandom, s);
            checks++;
            if (s !== k % N) begin failures++; $display("FAIL rr_order: got %0d required %0d", s, k % N); end
            drive_req(s, 1'($urandom), 1'($urandom), 24'($urandom), $urandom);
        end
        for (int i = 0; i < N; i++) begin req_valid[i] = 1'b0; pend[i] = 1'b0; end
        @(negedge clk);
        // A grant may have been taken in that idle cycle; restart cleanly.
        do_reset();
    endtask

    task automatic test_timeout();
        int s;
        drive_req(0, 1'b0, 1'b0, 24'h00DEAD, 32'h0);
        serve(TMO + 5, 32'hCAFE_CAFE, s);
        drive_req(3, 1'b0, 1'b1, 24'h00BEEF, 32'h0);
        serve(TMO, 32'h5A5A_A5A5, s);
    endtask

    task automatic test_reset_mid();
        int s;
        do_reset();
        drive_req(2, 1'b0, 1'b0, 24'h000042, 32'h0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || owner !== 2'd2) begin
            failures++;
            $display("FAIL mid_grant: got busy=%b owner=%0d required 1 2", busy, owner);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || owner !== 2'd0 || cache_r_en !== 1'b0 || cache_w_en !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got busy=%b owner=%0d r=%b w=%b required 0", busy, owner, cache_r_en, cache_w_en);
        end
        req_valid[2] = 1'b0;
        pend[2]      = 1'b0;
        rr_m         = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (req_done !== '0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL no_done_after_reset: got done=%b busy=%b required 0 0", req_done, busy);
            end
        end
        drive_req(1, 1'b1, 1'b0, 24'h000011, 32'hA);
        drive_req(3, 1'b0, 1'b0, 24'h000033, 32'hB);
        serve(2, 32'h77, s);
        checks++;
        if (s !== 1) begin failures++; $display("FAIL rr_after_reset: got %0d required 1", s); end
        serve(1, 32'h88, s);
    endtask

    task automatic test_random();
        int s;
        int budget;
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    drive_req(i, 1'($urandom), 1'($urandom), 24'($urandom), $urandom);
            end
            budget = 12;
            while (pick() >= 0 && budget > 0) begin
                serve($urandom_range(1, TMO + 2), $urandom, s);
                if ($urandom_range(0, 3) == 0 && !pend[s])
                    drive_req(s, 1'($urandom), 1'($urandom), 24'($urandom), $urandom);
                budget--;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_read();
        test_write_through();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
